// File: rtl/subtree_pkg.sv
// -----------------------------------------------------------------------------
// subtree_pkg
//   Types and helpers shared by the subtree fan-in nodes.
//   - subtree_state_t : collection round state (IDLE, COLLECT, DRAIN, DONE)
//   - clog2_min1      : index width for an N-entry selector, never below 1 bit
// -----------------------------------------------------------------------------
package subtree_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } subtree_state_t;

    // A one-entry selector still needs a 1-bit index port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : subtree_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter over N requesters. The grant goes to the first set
//   request found scanning upward from the internal pointer, with wrap-around.
//   When the caller consumes the grant (advance), the pointer moves to the
//   requester just after the winner, so every requester is served in turn.
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset (pointer -> 0)
//   req         per-requester request
//   advance     grant was used this cycle; rotate the pointer past the winner
//   grant       one-hot grant (zero when no request)
//   grant_idx   binary index of the granted requester
//   grant_any   at least one request is granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import subtree_pkg::*;
#(
    parameter int N = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req,
    input  logic                       advance,
    output logic [N-1:0]               grant,
    output logic [clog2_min1(N)-1:0]   grant_idx,
    output logic                       grant_any
);

    localparam int IDX_W = clog2_min1(N);

    logic [IDX_W-1:0] ptr;

    // NOTE: every signal driven from always_comb gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_any) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule : rr_arbiter

// File: rtl/subtree_result_collector.sv
// -----------------------------------------------------------------------------
// subtree_result_collector
//   Gathers result beats from N_CHILD child sub-trees into one registered
//   stream toward the parent. Children are served round-robin; every output
//   beat carries its source child index. A round starts with `start`, collects
//   until every child has reported done, drains remaining beats, then pulses
//   all_done for one cycle.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   start        one-cycle pulse, begins a round (ignored outside IDLE)
//   in_valid     per-child beat valid
//   in_ready     per-child accept, one-hot or zero
//   in_data      child i payload at [i*DATA_W +: DATA_W]
//   child_done   per-child "no further beats" (level or pulse, sticky inside)
//   out_valid    registered output beat valid
//   out_ready    downstream accept
//   out_data     payload of the current output beat
//   out_src      child index of the current output beat
//   beat_cnt     beats accepted this round, saturating
//   busy         round in progress (COLLECT or DRAIN)
//   all_done     one-cycle pulse on entering DONE
// -----------------------------------------------------------------------------
module subtree_result_collector
    import subtree_pkg::*;
#(
    parameter int N_CHILD = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [N_CHILD-1:0]                in_valid,
    output logic [N_CHILD-1:0]                in_ready,
    input  logic [N_CHILD*DATA_W-1:0]         in_data,
    input  logic [N_CHILD-1:0]                child_done,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic [clog2_min1(N_CHILD)-1:0]    out_src,
    output logic [CNT_W-1:0]                  beat_cnt,
    output logic                              busy,
    output logic                              all_done
);

    localparam int IDX_W = clog2_min1(N_CHILD);

    subtree_state_t     state, state_nxt;
    logic [N_CHILD-1:0] done_mask;
    logic [N_CHILD-1:0] done_upd;
    logic               arb_en;
    logic [N_CHILD-1:0] req;
    logic [N_CHILD-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               slot_free;
    logic               load;
    logic               round_start;
    logic [DATA_W-1:0]  sel_data;

    assign arb_en      = (state == ST_COLLECT) || (state == ST_DRAIN);
    assign req         = in_valid & {N_CHILD{arb_en}};
    // The output slot can take a beat when empty or emptying this cycle,
    // which gives one beat per cycle under continuous out_ready.
    assign slot_free   = !out_valid || out_ready;
    assign load        = slot_free && grant_any;
    assign in_ready    = load ? grant : '0;
    assign round_start = (state == ST_IDLE) && start;
    // Include this cycle's child_done so the last report moves to DRAIN
    // without an extra cycle.
    assign done_upd    = done_mask | child_done;
    assign sel_data    = in_data[int'(grant_idx)*DATA_W +: DATA_W];

    rr_arbiter #(
        .N (N_CHILD)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        all_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                busy = 1'b1;
                if (&done_upd) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Finished once no child is offering and the output slot is
                // empty or being accepted right now.
                if ((in_valid == '0) && slot_free) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                all_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round bookkeeping: done mask and accepted-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_mask <= '0;
            beat_cnt  <= '0;
        end else begin
            if (round_start) begin
                done_mask <= '0;
            end else if (state == ST_COLLECT) begin
                done_mask <= done_upd;
            end

            if (round_start) begin
                beat_cnt <= '0;
            end else if (load && (beat_cnt != '1)) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Output register. A beat stays put while out_valid && !out_ready.
    // NOTE: the payload register is reset too, even though out_valid alone
    // qualifies it, so out_data reads 0 after reset rather than stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : subtree_result_collector

// File: tb/tb_subtree_result_collector.sv
// -----------------------------------------------------------------------------
// tb_subtree_result_collector
//   Directed bench for subtree_result_collector (N_CHILD=5, DATA_W=32,
//   CNT_W=16) plus a small second instance (N_CHILD=2, CNT_W=3) for
//   beat_cnt saturation. Inputs are driven 1 ns after the rising edge,
//   combinational outputs are checked 1 ns later, registered outputs right
//   after each edge.
// -----------------------------------------------------------------------------
module tb_subtree_result_collector;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    child_done;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_src;
    logic [CW-1:0]   beat_cnt;
    logic            busy;
    logic            all_done;

    // Saturation instance.
    logic        s_start;
    logic [1:0]  s_in_valid;
    logic [1:0]  s_in_ready;
    logic [15:0] s_in_data;
    logic [1:0]  s_child_done;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic [0:0]  s_out_src;
    logic [2:0]  s_beat_cnt;
    logic        s_busy;
    logic        s_all_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    subtree_result_collector #(
        .N_CHILD (N),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .child_done (child_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .beat_cnt   (beat_cnt),
        .busy       (busy),
        .all_done   (all_done)
    );

    subtree_result_collector #(
        .N_CHILD (2),
        .DATA_W  (8),
        .CNT_W   (3)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .start      (s_start),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .child_done (s_child_done),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_data   (s_out_data),
        .out_src    (s_out_src),
        .beat_cnt   (s_beat_cnt),
        .busy       (s_busy),
        .all_done   (s_all_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        start        = 1'b0;
        in_valid     = '0;
        in_data      = '0;
        child_done   = '0;
        out_ready    = 1'b1;
        s_start      = 1'b0;
        s_in_valid   = '0;
        s_in_data    = 16'h0201;
        s_child_done = '0;
        s_out_ready  = 1'b1;
        #13;
        checks++;
        if ({out_valid, out_data, out_src, beat_cnt, busy, all_done, in_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b data=%h src=%0d cnt=%0d busy=%b done=%b rdy=%b, expected all 0",
                     out_valid, out_data, out_src, beat_cnt, busy, all_done, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_rdy;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || beat_cnt !== '0) begin
            failures++;
            $display("FAIL fair_start: busy=%b cnt=%0d, expected busy=1 cnt=0", busy, beat_cnt);
        end
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'h1000_0000 + i;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_rdy = '0;
            exp_rdy[k % N] = 1'b1;
            #1;
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL fair_in_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== IW'(k % N) || out_data !== 32'h1000_0000 + (k % N)) begin
                failures++;
                $display("FAIL fair_beat[%0d]: valid=%b src=%0d data=%h, expected 1 %0d %h",
                         k, out_valid, out_src, out_data, k % N, 32'h1000_0000 + (k % N));
            end
        end
        checks++;
        if (beat_cnt !== 16'd10) begin
            failures++;
            $display("FAIL fair_beat_cnt: got %0d expected 10", beat_cnt);
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fair_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    // Pointer is at 0 here, so child 2 is granted first.
    task automatic test_backpressure();
        in_data[2*DW +: DW] = 32'hA5A5_0002;
        in_valid  = 5'b00100;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 5'b00100) begin
            failures++;
            $display("FAIL bp_first_grant: got %b expected 00100", in_ready);
        end
        tick();
        in_data[2*DW +: DW] = 32'hA5A5_0012;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (in_ready !== '0 || out_valid !== 1'b1 || out_data !== 32'hA5A5_0002 || out_src !== 3'd2) begin
                failures++;
                $display("FAIL bp_hold[%0d]: rdy=%b valid=%b data=%h src=%0d, expected 00000 1 a5a50002 2",
                         c, in_ready, out_valid, out_data, out_src);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 5'b00100) begin
            failures++;
            $display("FAIL bp_release_grant: got %b expected 00100", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0012 || beat_cnt !== 16'd12) begin
            failures++;
            $display("FAIL bp_next_beat: valid=%b data=%h cnt=%0d, expected 1 a5a50012 12",
                     out_valid, out_data, beat_cnt);
        end
        in_valid = '0;
        tick();
    endtask

    // Pointer is at 3 here; a lone child 1 beat moves it to 2.
    task automatic test_sparse();
        logic [N-1:0]  exp_rdy [3];
        logic [IW-1:0] exp_src [3];
        exp_rdy = '{5'b01000, 5'b00010, 5'b01000};
        exp_src = '{3'd3, 3'd1, 3'd3};
        in_data[1*DW +: DW] = 32'hB0B0_0001;
        in_data[3*DW +: DW] = 32'hB0B0_0003;
        in_valid  = 5'b00010;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 5'b00010) begin
            failures++;
            $display("FAIL sparse_setup: got %b expected 00010", in_ready);
        end
        tick();
        in_valid = 5'b01010;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== exp_rdy[k]) begin
                failures++;
                $display("FAIL sparse_in_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy[k]);
            end
            tick();
            checks++;
            if (out_src !== exp_src[k] || out_data !== 32'hB0B0_0000 + 32'(exp_src[k])) begin
                failures++;
                $display("FAIL sparse_beat[%0d]: src=%0d data=%h, expected %0d", k, out_src, out_data, exp_src[k]);
            end
        end
        checks++;
        if (beat_cnt !== 16'd16) begin
            failures++;
            $display("FAIL sparse_beat_cnt: got %0d expected 16", beat_cnt);
        end
        in_valid = '0;
        tick();
    endtask

    // Pointer is at 4 here.
    task automatic test_completion();
        out_ready = 1'b1;
        in_valid  = '0;
        for (int i = 0; i < 4; i++) begin
            child_done = '0;
            child_done[i] = 1'b1;
            tick();
            checks++;
            if (busy !== 1'b1 || all_done !== 1'b0) begin
                failures++;
                $display("FAIL done_partial[%0d]: busy=%b all_done=%b, expected 1 0", i, busy, all_done);
            end
        end
        child_done = '0;
        in_data[4*DW +: DW] = 32'hD0D0_0004;
        in_valid  = 5'b10000;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 5'b10000) begin
            failures++;
            $display("FAIL done_last_grant: got %b expected 10000", in_ready);
        end
        tick();
        in_valid   = '0;
        child_done = 5'b10000;
        tick();
        child_done = '0;
        checks++;
        if (busy !== 1'b1 || all_done !== 1'b0 || out_valid !== 1'b1 || out_src !== 3'd4) begin
            failures++;
            $display("FAIL done_drain_enter: busy=%b all_done=%b valid=%b src=%0d, expected 1 0 1 4",
                     busy, all_done, out_valid, out_src);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || all_done !== 1'b0) begin
            failures++;
            $display("FAIL done_drain_hold: busy=%b all_done=%b, expected 1 0", busy, all_done);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (all_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: all_done=%b busy=%b valid=%b, expected 1 0 0", all_done, busy, out_valid);
        end
        tick();
        checks++;
        if (all_done !== 1'b0 || busy !== 1'b0 || beat_cnt !== 16'd17) begin
            failures++;
            $display("FAIL done_after: all_done=%b busy=%b cnt=%0d, expected 0 0 17", all_done, busy, beat_cnt);
        end
    endtask

    // Pointer is at 0 here.
    task automatic test_simultaneous();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || beat_cnt !== '0) begin
            failures++;
            $display("FAIL sim_start: busy=%b cnt=%0d, expected 1 0", busy, beat_cnt);
        end
        child_done = 5'b01111;
        tick();
        child_done = 5'b10000;
        in_valid   = 5'b10000;
        in_data[4*DW +: DW] = 32'hE0E0_0004;
        out_ready  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 5'b10000) begin
            failures++;
            $display("FAIL sim_grant: got %b expected 10000", in_ready);
        end
        tick();
        child_done = '0;
        in_valid   = '0;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 3'd4 || out_data !== 32'hE0E0_0004 ||
            beat_cnt !== 16'd1 || busy !== 1'b1 || all_done !== 1'b0) begin
            failures++;
            $display("FAIL sim_beat: valid=%b src=%0d data=%h cnt=%0d busy=%b done=%b, expected 1 4 e0e00004 1 1 0",
                     out_valid, out_src, out_data, beat_cnt, busy, all_done);
        end
        tick();
        checks++;
        if (all_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sim_done: all_done=%b valid=%b busy=%b, expected 1 0 0", all_done, out_valid, busy);
        end
        tick();
        checks++;
        if (all_done !== 1'b0) begin
            failures++;
            $display("FAIL sim_done_once: all_done=%b expected 0", all_done);
        end
    endtask

    task automatic test_reset_mid_round();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'h2000_0000 + i;
        in_valid  = '1;
        out_ready = 1'b1;
        repeat (7) tick();
        checks++;
        if (beat_cnt !== 16'd7 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_seven: cnt=%0d valid=%b, expected 7 1", beat_cnt, out_valid);
        end
        in_valid  = '0;
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (beat_cnt !== 16'd7 || out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_start_ignored: cnt=%0d valid=%b busy=%b, expected 7 1 1", beat_cnt, out_valid, busy);
        end
        in_valid  = '1;
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, out_src, beat_cnt, busy, all_done, in_ready} !== '0) begin
            failures++;
            $display("FAIL mid_async_reset: valid=%b data=%h src=%0d cnt=%0d busy=%b done=%b rdy=%b, expected all 0",
                     out_valid, out_data, out_src, beat_cnt, busy, all_done, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        start = 1'b1;
        #1;
        checks++;
        if (in_ready !== '0) begin
            failures++;
            $display("FAIL mid_idle_no_grant: got %b expected 00000", in_ready);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || beat_cnt !== '0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_clean_start: busy=%b cnt=%0d valid=%b, expected 1 0 0", busy, beat_cnt, out_valid);
        end
        #1;
        checks++;
        if (in_ready !== 5'b00001) begin
            failures++;
            $display("FAIL mid_ptr_reset: got %b expected 00001", in_ready);
        end
        tick();
        in_valid = '0;
        checks++;
        if (out_src !== 3'd0 || out_data !== 32'h2000_0000 || beat_cnt !== 16'd1) begin
            failures++;
            $display("FAIL mid_first_beat: src=%0d data=%h cnt=%0d, expected 0 20000000 1", out_src, out_data, beat_cnt);
        end
    endtask

    task automatic test_saturation();
        s_start = 1'b1;
        tick();
        s_start     = 1'b0;
        s_in_valid  = 2'b11;
        s_out_ready = 1'b1;
        repeat (7) tick();
        checks++;
        if (s_beat_cnt !== 3'd7) begin
            failures++;
            $display("FAIL sat_reach_max: got %0d expected 7", s_beat_cnt);
        end
        repeat (3) tick();
        checks++;
        if (s_beat_cnt !== 3'd7 || s_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: cnt=%0d valid=%b, expected 7 1", s_beat_cnt, s_out_valid);
        end
        s_in_valid = '0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_sparse();
        test_completion();
        test_simultaneous();
        test_reset_mid_round();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_subtree_result_collector
